// File: rtl/game_link_rx.sv
// Pong link receiver: 8N1 UART deserialiser feeding a 9-byte game-state frame parser,
// with registered remote-state outputs and a frame-activity link timer.
module game_link_rx #(
  parameter int unsigned CLK_HZ         = 65_000_000,
  parameter int unsigned BAUD           = 115_200,
  parameter int unsigned TIMEOUT_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [10:0] x_ball,
  output logic [9:0]  y_ball,
  output logic [9:0]  y_pad,
  output logic [3:0]  player1_score,
  output logic [3:0]  player2_score,
  output logic [1:0]  state,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link_up
);

  localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SYNC    = 8'hA5;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic {P_HUNT, P_COLLECT} prs_state_t;

  logic             rx_meta, rx_sync, armed;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  bit_state_t       bit_state;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg, byte_data;
  logic             byte_stb;
  logic             stop_bad_c, frame_ok_c;

  prs_state_t       prs_state;
  logic [3:0]       idx;
  logic [7:0]       acc;
  logic [10:0]      sh_x;
  logic [9:0]       sh_y, sh_pad;
  logic [3:0]       sh_p1, sh_p2;
  logic [1:0]       sh_st;
  logic [TMO_W-1:0] link_cnt;

  // Two-flop synchroniser, idle-high reset value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick_c     = (div_cnt == DIV_W'(DIV - 1));
  assign stop_bad_c = (bit_state == B_STOP) && tick_c && (tick_cnt == 4'd15) && !rx_sync;
  assign frame_ok_c = byte_stb && (prs_state == P_COLLECT) && (idx == 4'd8) && (byte_data == acc);

  // Bit FSM; armed requires the line to be seen high before a falling edge counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_state <= B_IDLE;
      armed     <= 1'b0;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_data <= '0;
      byte_stb  <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      if (bit_state == B_IDLE || tick_c) div_cnt <= '0;
      else                               div_cnt <= div_cnt + DIV_W'(1);
      case (bit_state)
        B_IDLE: begin
          if (armed && !rx_sync) begin
            bit_state <= B_START;
            tick_cnt  <= '0;
            armed     <= 1'b0;
          end else begin
            armed <= rx_sync;
          end
        end
        B_START: if (tick_c) begin
          if (tick_cnt == 4'd7) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            if (rx_sync) begin
              bit_state <= B_IDLE;
              armed     <= 1'b1;
            end else begin
              bit_state <= B_DATA;
            end
          end else begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        B_DATA: if (tick_c) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) bit_state <= B_STOP;
          end
        end
        B_STOP: if (tick_c) begin
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            bit_state <= B_IDLE;
            armed     <= rx_sync;
            if (rx_sync) begin
              byte_stb  <= 1'b1;
              byte_data <= shreg;
            end
          end
        end
        default: bit_state <= B_IDLE;
      endcase
    end
  end

  // Frame parser, output registers and link timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prs_state     <= P_HUNT;
      idx           <= '0;
      acc           <= '0;
      sh_x          <= '0;
      sh_y          <= '0;
      sh_pad        <= '0;
      sh_p1         <= '0;
      sh_p2         <= '0;
      sh_st         <= '0;
      x_ball        <= '0;
      y_ball        <= '0;
      y_pad         <= '0;
      player1_score <= '0;
      player2_score <= '0;
      state         <= '0;
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      link_up       <= 1'b0;
      link_cnt      <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (stop_bad_c) begin
        frame_err <= 1'b1;
        prs_state <= P_HUNT;
      end else if (byte_stb) begin
        case (prs_state)
          P_HUNT: if (byte_data == SYNC) begin
            prs_state <= P_COLLECT;
            idx       <= 4'd1;
            acc       <= '0;
          end
          P_COLLECT: begin
            if (idx == 4'd8) begin
              prs_state <= P_HUNT;
              if (frame_ok_c) begin
                x_ball        <= sh_x;
                y_ball        <= sh_y;
                y_pad         <= sh_pad;
                player1_score <= sh_p1;
                player2_score <= sh_p2;
                state         <= sh_st;
                frame_valid   <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              acc <= acc ^ byte_data;
              idx <= idx + 4'd1;
              case (idx)
                4'd1: begin sh_st <= byte_data[5:4]; sh_x[10:8] <= byte_data[2:0]; end
                4'd2: sh_x[7:0]   <= byte_data;
                4'd3: sh_y[9:8]   <= byte_data[1:0];
                4'd4: sh_y[7:0]   <= byte_data;
                4'd5: sh_pad[9:8] <= byte_data[1:0];
                4'd6: sh_pad[7:0] <= byte_data;
                4'd7: begin sh_p1 <= byte_data[7:4]; sh_p2 <= byte_data[3:0]; end
                default: ;
              endcase
            end
          end
          default: prs_state <= P_HUNT;
        endcase
      end

      // A valid frame beats a coincident timeout
      if (frame_ok_c) begin
        link_cnt <= '0;
        link_up  <= 1'b1;
      end else if (link_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
        link_cnt <= link_cnt + TMO_W'(1);
        if (link_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) link_up <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_link_rx.sv
// Directed + randomized bench for game_link_rx: frames are built from random field values and
// decoded expectations come straight from those fields via a scoreboard queue.
module tb_game_link_rx;
  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned TMO    = 2000;
  localparam int unsigned BIT    = 16;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [9:0]  pad;
    logic [3:0]  p1;
    logic [3:0]  p2;
    logic [1:0]  st;
  } fr_t;

  logic        clk, rst, rx;
  logic [10:0] x_ball;
  logic [9:0]  y_ball, y_pad;
  logic [3:0]  player1_score, player2_score;
  logic [1:0]  state;
  logic        frame_valid, frame_err, link_up;

  game_link_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx(rx), .x_ball(x_ball), .y_ball(y_ball), .y_pad(y_pad),
    .player1_score(player1_score), .player2_score(player2_score), .state(state),
    .frame_valid(frame_valid), .frame_err(frame_err), .link_up(link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int fv_cnt = 0, fe_cnt = 0, fv_cyc = 0, fall_cyc = 0, fall_cnt = 0;
  logic link_q = 1'b0;
  fr_t expq[$];
  fr_t cur = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input fr_t e);
    chk({tag, ".x_ball"}, 32'(x_ball), 32'(e.x));
    chk({tag, ".y_ball"}, 32'(y_ball), 32'(e.y));
    chk({tag, ".y_pad"},  32'(y_pad),  32'(e.pad));
    chk({tag, ".p1"},     32'(player1_score), 32'(e.p1));
    chk({tag, ".p2"},     32'(player2_score), 32'(e.p2));
    chk({tag, ".state"},  32'(state),  32'(e.st));
  endtask

  // Scoreboard: every frame_valid must match the oldest expected frame
  always @(negedge clk) begin
    if (!rst) begin
      cur = '0;
      expq.delete();
    end else begin
      if (frame_valid) begin
        fv_cnt++;
        fv_cyc = cyc;
        if (expq.size() == 0) chk("unexpected_frame_valid", 32'd1, 32'd0);
        else begin
          cur = expq.pop_front();
          check_outs("sb", cur);
        end
      end
      if (frame_err) fe_cnt++;
      chk("valid_err_exclusive", 32'(frame_valid & frame_err), 32'd0);
    end
    if (link_q && !link_up) begin
      fall_cnt++;
      fall_cyc = cyc;
    end
    link_q = link_up;
  end

  function automatic fr_t rand_frame();
    fr_t f;
    f.x = 11'($urandom); f.y = 10'($urandom); f.pad = 10'($urandom);
    f.p1 = 4'($urandom); f.p2 = 4'($urandom); f.st = 2'($urandom);
    return f;
  endfunction

  // Reserved bits are random so they reach the checksum but must not reach the outputs
  function automatic void build(input fr_t f, input logic bad, output logic [7:0] b [9]);
    logic [7:0] r1, r3, r5;
    r1 = 8'($urandom); r3 = 8'($urandom); r5 = 8'($urandom);
    b[0] = 8'hA5;
    b[1] = {r1[7:6], f.st, r1[3], f.x[10:8]};
    b[2] = f.x[7:0];
    b[3] = {r3[7:2], f.y[9:8]};
    b[4] = f.y[7:0];
    b[5] = {r5[7:2], f.pad[9:8]};
    b[6] = f.pad[7:0];
    b[7] = {f.p1, f.p2};
    b[8] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7] ^ {7'd0, bad};
  endfunction

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop, BIT);
  endtask

  task automatic send_frame(input logic [7:0] b [9]);
    for (int i = 0; i < 9; i++) send_byte(b[i], 1'b1);
  endtask

  logic [7:0] fb [9];
  logic [7:0] t1 [9];
  fr_t f, t1_exp;
  int fv0, fe0, fall0, s, v2, lat;

  initial begin
    t1 = '{8'hA5, 8'h12, 8'hA5, 8'h01, 8'h2C, 8'h01, 8'h80, 8'h34, 8'h2F};
    t1_exp = '{x: 11'd677, y: 10'd300, pad: 10'd384, p1: 4'd3, p2: 4'd4, st: 2'b01};
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check_outs("reset", '0);
    chk("reset.link_up", 32'(link_up), 32'd0);
    chk("reset.frame_valid", 32'(frame_valid), 32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);
    rst = 1'b1;
    drive(1'b1, 20);

    // Bad checksum straight after reset: outputs and link stay at reset values
    fe0 = fe_cnt; fv0 = fv_cnt;
    fb = t1; fb[8] = 8'h2E;
    send_frame(fb); drive(1'b1, 20);
    chk("t2a.err_pulses", 32'(fe_cnt - fe0), 32'd1);
    chk("t2a.valid_pulses", 32'(fv_cnt - fv0), 32'd0);
    check_outs("t2a", '0);
    chk("t2a.link_up", 32'(link_up), 32'd0);

    // Worked example frame
    fv0 = fv_cnt; fe0 = fe_cnt;
    expq.push_back(t1_exp);
    send_frame(t1); drive(1'b1, 20);
    chk("t1.valid_pulses", 32'(fv_cnt - fv0), 32'd1);
    chk("t1.err_pulses", 32'(fe_cnt - fe0), 32'd0);
    check_outs("t1", t1_exp);
    chk("t1.link_up", 32'(link_up), 32'd1);

    // Random bad-checksum frame: outputs hold, link unchanged
    fe0 = fe_cnt; fv0 = fv_cnt;
    build(rand_frame(), 1'b1, fb);
    send_frame(fb); drive(1'b1, 20);
    chk("t2b.err_pulses", 32'(fe_cnt - fe0), 32'd1);
    chk("t2b.valid_pulses", 32'(fv_cnt - fv0), 32'd0);
    check_outs("t2b", t1_exp);
    chk("t2b.link_up", 32'(link_up), 32'd1);

    // Back-to-back random frames, some with 0xA5 in the x low byte
    fv0 = fv_cnt;
    for (int k = 0; k < 5; k++) begin
      f = rand_frame();
      if (k[0]) f.x[7:0] = 8'hA5;
      expq.push_back(f);
      build(f, 1'b0, fb);
      send_frame(fb);
    end
    drive(1'b1, 20);
    chk("b2b.valid_pulses", 32'(fv_cnt - fv0), 32'd5);
    check_outs("b2b", f);

    // Garbage ahead of the worked example
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h3C, 1'b1);
    expq.push_back(t1_exp);
    send_frame(t1); drive(1'b1, 20);
    chk("t3.valid_pulses", 32'(fv_cnt - fv0), 32'd1);
    chk("t3.err_pulses", 32'(fe_cnt - fe0), 32'd0);
    check_outs("t3", t1_exp);

    // Short glitch is a false start
    fv0 = fv_cnt; fe0 = fe_cnt;
    drive(1'b0, 4); drive(1'b1, 300);
    chk("t4.glitch_err", 32'(fe_cnt - fe0), 32'd0);
    chk("t4.glitch_valid", 32'(fv_cnt - fv0), 32'd0);

    // Stop bit low on B4 aborts the frame
    build(rand_frame(), 1'b0, fb);
    for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b1);
    send_byte(fb[4], 1'b0);
    drive(1'b1, 300);
    chk("t4.stop_err", 32'(fe_cnt - fe0), 32'd1);
    chk("t4.stop_valid", 32'(fv_cnt - fv0), 32'd0);
    check_outs("t4.hold", t1_exp);
    fv0 = fv_cnt;
    f = rand_frame();
    expq.push_back(f);
    build(f, 1'b0, fb);
    send_frame(fb); drive(1'b1, 20);
    chk("t4.recover_valid", 32'(fv_cnt - fv0), 32'd1);
    check_outs("t4.recover", f);

    // Link timeout exactly TMO cycles after the last frame_valid
    fall0 = fall_cnt;
    f = rand_frame();
    expq.push_back(f);
    build(f, 1'b0, fb);
    send_frame(fb);
    for (int i = 0; i < 2200 && fall_cnt == fall0; i++) @(negedge clk);
    chk("t5.fell", 32'(fall_cnt - fall0), 32'd1);
    chk("t5.fall_delay", 32'(fall_cyc - fv_cyc), 32'(TMO));
    chk("t5.link_up", 32'(link_up), 32'd0);
    check_outs("t5.hold", f);

    // Frame whose frame_valid lands on the timeout cycle keeps the link up
    fall0 = fall_cnt;
    f = rand_frame();
    expq.push_back(f);
    build(f, 1'b0, fb);
    s = cyc;
    send_frame(fb); drive(1'b1, 20);
    v2 = fv_cyc; lat = v2 - s;
    for (int i = 0; i < 3000 && cyc < v2 + int'(TMO) - lat; i++) @(negedge clk);
    f = rand_frame();
    expq.push_back(f);
    build(f, 1'b0, fb);
    send_frame(fb); drive(1'b1, 20);
    chk("t5.coincide_align", 32'(fv_cyc - v2), 32'(TMO));
    chk("t5.coincide_no_fall", 32'(fall_cnt - fall0), 32'd0);
    chk("t5.coincide_link_up", 32'(link_up), 32'd1);
    check_outs("t5.coincide", f);

    // Reset in the middle of B5
    build(rand_frame(), 1'b0, fb);
    for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b1);
    drive(1'b0, BIT);
    drive(fb[5][0], BIT);
    drive(fb[5][1], 7);
    rst = 1'b0;
    @(negedge clk);
    check_outs("t6.in_reset", '0);
    chk("t6.in_reset_link", 32'(link_up), 32'd0);
    drive(1'b1, 10);
    rst = 1'b1;
    drive(1'b1, 50);
    fv0 = fv_cnt; fe0 = fe_cnt;
    f = rand_frame();
    expq.push_back(f);
    build(f, 1'b0, fb);
    send_frame(fb); drive(1'b1, 20);
    chk("t6.valid_pulses", 32'(fv_cnt - fv0), 32'd1);
    chk("t6.err_pulses", 32'(fe_cnt - fe0), 32'd0);
    check_outs("t6", f);
    chk("t6.link_up", 32'(link_up), 32'd1);

    chk("end.pending_frames", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
